// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data_mem.
// Each command gets a one-cycle grant. A write takes IDLE->ACCESS->IDLE.
// A read takes IDLE->ACCESS->RCAP->IDLE and returns data with a one-cycle rvalid.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wEn,
  output logic                  mem_rEn,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RCAP} state_t;

  state_t                state_q;
  logic                  last_q;   // last winner; also the in-flight owner once granted
  logic                  we_q;     // latched direction of the in-flight command
  logic                  gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, busy_q;
  logic                  mem_wEn_q, mem_rEn_q;
  logic [DATA_WIDTH-1:0] rdata_q, mem_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  win_d;    // 0 = port 0 wins, 1 = port 1 wins

  // Winner pick: the sole requester, or the port that did not win last time.
  always_comb begin
    win_d = req1;
    if (req0 && req1) win_d = ~last_q;
  end

  // Arbitration and sequencing FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      busy_q     <= 1'b0;
      mem_wEn_q  <= 1'b0;
      mem_rEn_q  <= 1'b0;
      rdata_q    <= '0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
    end else begin
      // Grants and rvalids are single-cycle pulses.
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt0_q     <= ~win_d;
            gnt1_q     <= win_d;
            mem_addr_q <= win_d ? addr1 : addr0;
            mem_data_q <= win_d ? wdata1 : wdata0;
            mem_wEn_q  <= win_d ? we1 : we0;
            mem_rEn_q  <= win_d ? ~we1 : ~we0;
            we_q       <= win_d ? we1 : we0;
            last_q     <= win_d;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          // data_mem performs the access at this edge; drop the enables.
          mem_wEn_q <= 1'b0;
          mem_rEn_q <= 1'b0;
          if (we_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= RCAP;
          end
        end
        RCAP: begin
          rdata_q   <= mem_out;
          rvalid0_q <= ~last_q;
          rvalid1_q <= last_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_wEn_q <= 1'b0;
          mem_rEn_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mem_data = mem_data_q;
  assign mem_addr = mem_addr_q;
  assign mem_wEn  = mem_wEn_q;
  assign mem_rEn  = mem_rEn_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural data_mem.
// The stimulus pushes the expected grants, and a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_wEn, mem_rEn;
  logic [7:0] rdata, mem_data, mem_addr, mem_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic port; logic we; logic [7:0] addr; logic [7:0] data; logic [7:0] rd; } gexp_t;
  typedef struct { logic port; logic [7:0] rd; int gc; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t ge;
  rexp_t re;

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_wEn(mem_wEn), .mem_rEn(mem_rEn),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // data_mem model: write commits at the edge, read data appears the cycle after.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_wEn) mem[mem_addr] <= mem_data;
    if (mem_rEn) mem_out <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic expg(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] r);
    gq.push_back('{port: p, we: w, addr: a, data: d, rd: r});
  endtask

  // Monitor: every grant must match the next expected command, and every rvalid must match its read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'({gnt1, gnt0}), 0);
        end else begin
          ge = gq.pop_front();
          chk("gnt_port", 32'({gnt1, gnt0}), ge.port ? 2 : 1);
          chk("gnt_busy", 32'(busy), 1);
          chk("gnt_mem_wEn", 32'(mem_wEn), 32'(ge.we));
          chk("gnt_mem_rEn", 32'(mem_rEn), 32'(!ge.we));
          chk("gnt_mem_addr", 32'(mem_addr), 32'(ge.addr));
          if (ge.we) chk("gnt_mem_data", 32'(mem_data), 32'(ge.data));
          else rq.push_back('{port: ge.port, rd: ge.rd, gc: cyc});
        end
      end else if (mem_wEn || mem_rEn) begin
        chk("enable_without_gnt", 32'({mem_wEn, mem_rEn}), 0);
      end
      if (rvalid0 || rvalid1) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 0);
        end else begin
          re = rq.pop_front();
          chk("rvalid_port", 32'({rvalid1, rvalid0}), re.port ? 2 : 1);
          chk("rdata", 32'(rdata), 32'(re.rd));
          chk("rvalid_latency", cyc - re.gc, 2);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 0);
    chk({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_en"}, 32'({mem_wEn, mem_rEn}), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present commands, then drop each req once its grant is seen, and let the last access drain.
  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int i = 0; i < 20 && (req0 || req1); i++) begin
      @(posedge clk); #1;
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
    end
    chk("drive_timeout", 32'({req1, req0}), 0);
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic p);
    logic ok;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (p ? gnt1 : gnt0) ok = 1;
    end
    chk("wait_gnt_timeout", 32'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, idle, n0, n1;
    logic [7:0] shadow [8];
    logic seen [8];
    logic p0, p1, lg, win, w;
    logic [7:0] a, d;
    int cnt;

    do_reset();

    // 1. Single write, then read-back on port 0.
    expg(0, 1, 8'h02, 8'h22, 8'h00);
    req0 = 1; we0 = 1; addr0 = 8'h02; wdata0 = 8'h22;
    @(posedge clk); #1;
    chk("t1_gnt0_latency", 32'(gnt0), 1);
    chk("t1_wen_high", 32'(mem_wEn), 1);
    req0 = 0;
    @(posedge clk); #1;
    chk("t1_wen_one_cycle", 32'(mem_wEn), 0);
    chk("t1_busy_after_write", 32'(busy), 0);
    chk("t1_mem_committed", 32'(mem[2]), 32'h22);
    expg(0, 0, 8'h02, 8'h00, 8'h22);
    drive(1, 0, 8'h02, 8'h00, 0, 0, 8'h00, 8'h00);

    // 2. Contention straight out of reset: port 0 first.
    do_reset();
    expg(0, 1, 8'h00, 8'h10, 8'h00);
    expg(1, 1, 8'h01, 8'h11, 8'h00);
    drive(1, 1, 8'h00, 8'h10, 1, 1, 8'h01, 8'h11);
    expg(0, 0, 8'h00, 8'h00, 8'h10);
    drive(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    expg(1, 0, 8'h01, 8'h00, 8'h11);
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);

    // 3. Both held for six grants: strict alternation and one idle cycle between writes.
    for (int i = 0; i < 3; i++) begin
      expg(0, 1, 8'h20, 8'hA0, 8'h00);
      expg(1, 1, 8'h21, 8'hB1, 8'h00);
    end
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'hA0;
    req1 = 1; we1 = 1; addr1 = 8'h21; wdata1 = 8'hB1;
    ng = 0; idle = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) ng++;
      else if (ng > 0 && !busy) idle++;
      if (gnt0) begin n0++; if (n0 == 3) req0 = 0; end
      if (gnt1) begin n1++; if (n1 == 3) req1 = 0; end
    end
    req0 = 0; req1 = 0;
    chk("t3_grants", ng, 6);
    chk("t3_idle_cycles", idle, 5);
    repeat (3) @(posedge clk);
    #1;

    // 4. Reset while a port-1 read sits in RCAP: the read is dropped.
    expg(1, 0, 8'h01, 8'h00, 8'h11);
    req1 = 1; we1 = 0; addr1 = 8'h01;
    wait_gnt(1);
    req1 = 0;
    @(posedge clk); #1;
    chk("t4_in_rcap_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    rq.delete();
    chk_zero("t4_midread");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    expg(0, 1, 8'h03, 8'h33, 8'h00);
    expg(1, 1, 8'h04, 8'h44, 8'h00);
    drive(1, 1, 8'h03, 8'h33, 1, 1, 8'h04, 8'h44);

    // 5. Inputs that change during a read are ignored.
    expg(1, 1, 8'h05, 8'h55, 8'h00);
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 8'h55);
    expg(0, 0, 8'h05, 8'h00, 8'h55);
    req0 = 1; we0 = 0; addr0 = 8'h05;
    wait_gnt(0);
    addr0 = 8'h09; we0 = 1; wdata0 = 8'h99;
    @(posedge clk); #1;
    chk("t5_addr_held_access", 32'(mem_addr), 32'h05);
    chk("t5_no_extra_en", 32'({mem_wEn, mem_rEn}), 0);
    we0 = 0;
    @(posedge clk); #1;
    chk("t5_addr_held_rcap", 32'(mem_addr), 32'h05);
    chk("t5_rvalid0", 32'(rvalid0), 1);
    chk("t5_rdata", 32'(rdata), 32'h55);
    req0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_mem9_untouched", 32'(mem[9] === 8'h99), 0);

    // 6. Random traffic on 0x80..0x87.  Prediction uses the round-robin rule and a shadow memory.
    do_reset();
    for (int i = 0; i < 8; i++) begin seen[i] = 0; shadow[i] = 0; end
    p0 = 0; p1 = 0; lg = 1; cnt = 0;
    for (int cy = 0; cy < 400; cy++) begin
      @(posedge clk); #1;
      if (gnt0) begin p0 = 0; req0 = 0; end
      if (gnt1) begin p1 = 0; req1 = 0; end
      if (cy < 200 && !p0 && $urandom_range(1, 0) == 1) begin
        a = 8'h80 + 8'($urandom_range(7, 0));
        p0 = 1; req0 = 1; addr0 = a; wdata0 = 8'($urandom);
        we0 = !seen[a[2:0]] || ($urandom_range(1, 0) == 1);
      end
      if (cy < 200 && !p1 && $urandom_range(1, 0) == 1) begin
        a = 8'h80 + 8'($urandom_range(7, 0));
        p1 = 1; req1 = 1; addr1 = a; wdata1 = 8'($urandom);
        we1 = !seen[a[2:0]] || ($urandom_range(1, 0) == 1);
      end
      if (cnt > 0) begin
        cnt--;
      end else if (p0 || p1) begin
        win = (p0 && p1) ? !lg : p1;
        w = win ? we1 : we0;
        a = win ? addr1 : addr0;
        d = win ? wdata1 : wdata0;
        if (w) begin shadow[a[2:0]] = d; seen[a[2:0]] = 1; end
        expg(win, w, a, d, shadow[a[2:0]]);
        lg = win;
        cnt = w ? 1 : 2;
      end
      if (cy >= 200 && !p0 && !p1 && cnt == 0) break;
    end
    chk("t6_all_granted", 32'({p1, p0}), 0);
    req0 = 0; req1 = 0;
    repeat (5) @(posedge clk);
    #1;

    chk("gnt_queue_empty", gq.size(), 0);
    chk("rvalid_queue_empty", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
